// File: rtl/al_serial_alu_ctrl.sv
// rtl/al_serial_alu_ctrl.sv - bit-serial add/sub/compare sequencer around one full-adder slice
// Operands stream LSB-first through a single sum/carry slice, one bit per clock.
module al_serial_alu_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             le,
    output logic             busy
);

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_ALEB = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] sa_q;
    logic [WIDTH-1:0] sb_q;
    logic [WIDTH-1:0] res_q;
    logic [CW-1:0]    cnt_q;
    logic [1:0]       op_q;
    logic             c_q;
    logic             cout_q;
    logic             le_q;

    logic             sum_d;
    logic             carry_d;

    // The one shared adder slice.
    assign sum_d   = sa_q[0] ^ sb_q[0] ^ c_q;
    assign carry_d = (sa_q[0] & sb_q[0]) | (sa_q[0] & c_q) | (sb_q[0] & c_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            op_q    <= 2'b00;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
            le_q    <= 1'b0;
        end else if (flush) begin
            state_q <= S_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
            le_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        // Subtraction and compare run as x + ~y + 1; compare swaps so carry means a <= b.
                        case (op)
                            OP_SUB: begin
                                c_q  <= 1'b1;
                                sa_q <= a;
                                sb_q <= ~b;
                            end
                            OP_ALEB: begin
                                c_q  <= 1'b1;
                                sa_q <= b;
                                sb_q <= ~a;
                            end
                            default: begin
                                c_q  <= cin;
                                sa_q <= a;
                                sb_q <= b;
                            end
                        endcase
                        op_q    <= op;
                        cnt_q   <= '0;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    res_q <= {sum_d, res_q[WIDTH-1:1]};
                    sa_q  <= {1'b0, sa_q[WIDTH-1:1]};
                    sb_q  <= {1'b0, sb_q[WIDTH-1:1]};
                    c_q   <= carry_d;
                    if (cnt_q == LAST) begin
                        cnt_q   <= '0;
                        cout_q  <= carry_d;
                        le_q    <= (op_q == OP_ALEB) ? carry_d : 1'b0;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_RUN) || (state_q == S_DONE);
    assign result    = res_q;
    assign cout      = cout_q;
    assign le        = le_q;

endmodule

// File: tb/tb_al_serial_alu_ctrl.sv
// tb/tb_al_serial_alu_ctrl.sv - scoreboard bench for al_serial_alu_ctrl at WIDTH=8
module tb_al_serial_alu_ctrl;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] r;
        logic         c;
        logic         l;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   op;
    logic         cin;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         flush;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         cout;
    logic         le;
    logic         busy;

    al_serial_alu_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .cin(cin), .a(a), .b(b), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .cout(cout), .le(le), .busy(busy)
    );

    always #5 clk = ~clk;

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    exp_t sb_q[$];
    exp_t mon_e;
    logic prev_v = 1'b0;
    logic [W+1:0] prev_bits = '0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference behaviour stated in plain integer arithmetic.
    function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] av,
                                   input logic [W-1:0] bv, input logic ci);
        exp_t e;
        int unsigned ai = av;
        int unsigned bi = bv;
        int unsigned s;
        case (o)
            2'b01: begin
                e.r = W'((ai - bi) & 32'hFF);
                e.c = (ai >= bi);
                e.l = 1'b0;
            end
            2'b10: begin
                e.r = W'((bi - ai) & 32'hFF);
                e.c = (bi >= ai);
                e.l = (ai <= bi);
            end
            default: begin
                s   = ai + bi + ci;
                e.r = W'(s & 32'hFF);
                e.c = (s > 255);
                e.l = 1'b0;
            end
        endcase
        return e;
    endfunction

    function automatic exp_t mk(input logic [W-1:0] r, input logic c, input logic l);
        exp_t e;
        e.r = r;
        e.c = c;
        e.l = l;
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid && prev_v)
            check("hold_outputs", {result, cout, le}, prev_bits);
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_output", 1, 0);
            end else begin
                mon_e = sb_q.pop_front();
                check("result", result, mon_e.r);
                check("cout", cout, mon_e.c);
                check("le", le, mon_e.l);
            end
        end
        prev_v    = rst_n && out_valid;
        prev_bits = {result, cout, le};
    end

    task automatic issue(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic ci, input logic push, input exp_t e);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 0, 1);
        op = o; a = av; b = bv; cin = ci; in_valid = 1'b1;
        @(posedge clk);
        #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
        a  = W'($urandom);
        b  = W'($urandom);
        op = 2'($urandom);
        cin = 1'($urandom);
        if (push) sb_q.push_back(e);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 40);
    endtask

    task automatic run_op(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic ci, input exp_t e, input int stall);
        int lat;
        out_ready = (stall == 0);
        issue(o, av, bv, ci, 1'b1, e);
        check("in_ready_after_accept", in_ready, 0);
        check("busy_after_accept", busy, 1);
        wait_valid(lat);
        check("latency", lat, W);
        if (stall > 0) begin
            repeat (stall) @(posedge clk);
            #1 out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        check("in_ready_after_handshake", in_ready, 1);
    endtask

    task automatic count_valid(input string name);
        int n = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) n++;
        end
        check(name, n, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int   lat;
        int   last_acc;
        exp_t held;
        logic [1:0]   ro;
        logic [W-1:0] ra, rb;
        logic         rc;

        rst_n = 1'b0; in_valid = 1'b0; op = 2'b00; cin = 1'b0;
        a = '0; b = '0; flush = 1'b0; out_ready = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_result", result, 0);
        check("rst_cout", cout, 0);
        check("rst_le", le, 0);
        #21 rst_n = 1'b1;

        run_op(2'b00, 8'hFF, 8'h01, 1'b0, mk(8'h00, 1'b1, 1'b0), 0);
        run_op(2'b00, 8'h10, 8'h20, 1'b1, mk(8'h31, 1'b0, 1'b0), 0);
        run_op(2'b01, 8'h05, 8'h07, 1'b0, mk(8'hFE, 1'b0, 1'b0), 0);
        run_op(2'b01, 8'h07, 8'h05, 1'b0, mk(8'h02, 1'b1, 1'b0), 0);
        run_op(2'b10, 8'h03, 8'h03, 1'b0, mk(8'h00, 1'b1, 1'b1), 0);
        run_op(2'b10, 8'h04, 8'h03, 1'b0, mk(8'hFF, 1'b0, 1'b0), 0);
        run_op(2'b10, 8'h00, 8'hFF, 1'b0, mk(8'hFF, 1'b1, 1'b1), 0);
        run_op(2'b11, 8'h80, 8'h7F, 1'b1, mk(8'h00, 1'b1, 1'b0), 0);

        // Backpressure: hold DONE for five cycles.
        out_ready = 1'b0;
        held = mk(8'hC0, 1'b0, 1'b0);
        issue(2'b00, 8'h40, 8'h80, 1'b0, 1'b1, held);
        wait_valid(lat);
        check("bp_latency", lat, W);
        repeat (5) begin
            @(posedge clk);
            #1;
            check("bp_out_valid", out_valid, 1);
            check("bp_result", result, held.r);
            check("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_idle_next", in_ready, 1);
        check("bp_valid_drop", out_valid, 0);

        // Back-to-back issue with out_ready held high.
        for (int i = 0; i < 4; i++) begin
            ro = 2'($urandom); ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
            run_op(ro, ra, rb, rc, model(ro, ra, rb, rc), 0);
            if (i > 0) check("issue_interval", acc_cyc - last_acc, W + 2);
            last_acc = acc_cyc;
        end

        // Flush on the 4th RUN cycle with a competing in_valid.
        out_ready = 1'b1;
        issue(2'b00, 8'hAA, 8'h55, 1'b0, 1'b0, mk(8'h00, 1'b0, 1'b0));
        repeat (3) @(posedge clk);
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; op = 2'b01; a = 8'h11; b = 8'h22;
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        check("flush_in_ready", in_ready, 1);
        check("flush_busy", busy, 0);
        check("flush_out_valid", out_valid, 0);
        check("flush_result", result, 0);
        count_valid("flush_no_valid");
        run_op(2'b00, 8'h12, 8'h34, 1'b0, mk(8'h46, 1'b0, 1'b0), 0);

        // Asynchronous reset between clock edges mid-RUN.
        issue(2'b01, 8'h9C, 8'h21, 1'b0, 1'b0, mk(8'h00, 1'b0, 1'b0));
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_in_ready", in_ready, 1);
        check("arst_busy", busy, 0);
        check("arst_out_valid", out_valid, 0);
        check("arst_result", result, 0);
        check("arst_cout", cout, 0);
        check("arst_le", le, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        count_valid("arst_no_valid");
        run_op(2'b01, 8'h07, 8'h05, 1'b0, mk(8'h02, 1'b1, 1'b0), 0);

        // Randomized ops with random consumer stalls.
        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom);
            ra = ($urandom_range(0, 7) == 0) ? 8'hFF : W'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 8'h00 : W'($urandom);
            rc = 1'($urandom);
            run_op(ro, ra, rb, rc, model(ro, ra, rb, rc), int'($urandom_range(0, 3)));
        end

        repeat (4) @(posedge clk);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/al_serial_alu_ctrl.md
# al_serial_alu_ctrl

Bit-serial arithmetic sequencer that time-shares a single 1-bit full-adder slice across a WIDTH-bit operation.
- Supported operations: add, subtract, and unsigned A<=B compare, matching the ALUTYPE modes of the mapped adder primitive.
- Operation: accepts an operand pair over a valid/ready handshake, steps the carry through one bit per clock LSB-first, and presents result and flags over a second valid/ready handshake.
- Placement: sits between a register-file/command front end and the adder cell, for area-constrained Anlogic designs where a full carry chain is not affordable.

## Interface
Parameters:
- WIDTH, 16, operand/result width in bits; legal range 2..64.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand pair offered.
- in_ready  output  1  block can accept; high only in IDLE.
- op  input  2  00=ADD, 01=SUB, 10=A_LE_B, 11=reserved (executes as ADD).
- cin  input  1  carry-in, used by ADD only.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- flush  input  1  synchronous abort; returns to IDLE.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result.
- result  output  WIDTH  arithmetic result.
- cout  output  1  final carry; for SUB, 1 = no borrow.
- le  output  1  A_LE_B only: 1 when a <= b (unsigned); 0 for other ops.
- busy  output  1  high in RUN or DONE.

## Operation
States: IDLE, RUN, DONE.

IDLE:
- in_ready=1.
- On in_valid:
  - latch operands into shift registers sa, sb.
  - latch op into op_q.
  - preset carry:
    - ADD: c=cin, sa=a, sb=b.
    - SUB: c=1, sa=a, sb=~b.
    - A_LE_B: c=1, sa=b, sb=~a.
  - clear bit counter, go to RUN.

RUN, each cycle:
- Compute s=sa[0]^sb[0]^c and c'=majority(sa[0],sb[0],c).
- Shift s into the result shift register MSB (result fills LSB-first).
- Shift sa, sb right by one.
- Increment the counter.
- After the WIDTH-th bit: register cout=c', set le=c' if op_q==A_LE_B else 0, go to DONE.

DONE:
- out_valid=1.
- result, cout and le are held stable until out_ready; on out_ready go to IDLE.

flush:
- Effective in any state; next state IDLE.
- Clears out_valid; result/cout/le are cleared to 0.
- Takes priority over in_valid and out_ready in the same cycle.

Arithmetic rules:
- All arithmetic is modulo 2^WIDTH.
- A_LE_B result = b - a mod 2^WIDTH.
- Reserved op 11 behaves exactly as ADD, including use of cin.

## Timing
- Reset (rst_n low, asynchronous):
  - state=IDLE, in_ready=1, out_valid=0, busy=0.
  - result=0, cout=0, le=0; internal shift registers and counter cleared.
  - Deasserting reset mid-operation leaves the block idle; the in-flight operation is lost, with no output.
- Accept edge E0 = rising edge with in_valid && in_ready.
  - in_ready falls and busy rises after E0.
- out_valid rises after edge E0+WIDTH, i.e. latency WIDTH cycles from accept.
- result/cout/le are valid in the same cycle out_valid is first high; they do not toggle while out_valid=1.
- Handshake completes on the edge with out_valid && out_ready.
  - in_ready returns high the next cycle.
  - Minimum issue interval: WIDTH+2 cycles with out_ready held high.
- in_valid while in_ready=0 is ignored; the offerer must hold its data.
- Operand inputs are sampled only at E0; changes during RUN have no effect.
- The counter wraps exactly once per operation. No extra bit is processed for any WIDTH, including WIDTH=2.

## Test plan
All scenarios use WIDTH=8.
- ADD, a=0xFF, b=0x01, cin=0 -> result=0x00, cout=1, le=0; out_valid 8 cycles after accept. With cin=1: a=0x10, b=0x20 -> result=0x31, cout=0.
- SUB, a=0x05, b=0x07 -> result=0xFE, cout=0. Then a=0x07, b=0x05 -> result=0x02, cout=1.
- A_LE_B:
  - a=0x03, b=0x03 -> le=1, result=0x00.
  - a=0x04, b=0x03 -> le=0, result=0xFF.
  - a=0x00, b=0xFF -> le=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid stays 1, result unchanged, in_ready stays 0. Raise out_ready -> IDLE next cycle. Back-to-back ops with out_ready tied high issue every 10 cycles.
- flush asserted on the 4th RUN cycle, with in_valid also high -> IDLE next cycle, no out_valid pulse. Then a new ADD 0x12+0x34 -> 0x46.
- rst_n pulsed low asynchronously mid-RUN (between clock edges) -> outputs reach reset values immediately. After release, the first accepted op completes correctly, and no stale result appears.
